pix_multi_edge_sequencer: RTL and testbench

Parametrised, multi-channel successor to the single-structure PIX test sequencer. It drives N_EDGE independently timed, release-style control lines, such as _RESET and AOUT_RESET, into a pixel/TDC test structure. It also supports automatic repetition of the measurement window, abort, and completion reporting. It sits between the host-facing register block and the test-structure pads.

---
 rtl/pix_seq_pkg.sv | 19 +
 rtl/pix_multi_edge_sequencer_if.sv | 27 ++
 rtl/pix_seq_edge_channel.sv | 38 +++
 rtl/pix_multi_edge_sequencer.sv | 179 +++++++++++++++++
 tb/tb_pix_multi_edge_sequencer.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pix_seq_pkg.sv
// pix_seq_pkg: shared definitions for the multi-edge PIX test sequencer.
//   - SEQ_* : sequencer state encoding (2 bits, legacy-compatible constants)
//   - PIX_SEQ_INIT_CYCLES : default INIT dwell (INIT exits when cnt equals it)
//   - eff_repeats() : repeat count with 0 mapped to 1
package pix_seq_pkg;

    localparam logic [1:0] SEQ_INIT    = 2'd0;
    localparam logic [1:0] SEQ_READY   = 2'd1;
    localparam logic [1:0] SEQ_MEASURE = 2'd2;
    localparam logic [1:0] SEQ_FINAL   = 2'd3;

    localparam int PIX_SEQ_INIT_CYCLES = 20;

    // A request for zero measurements still runs one window.
    function automatic logic [7:0] eff_repeats(input logic [7:0] n);
        return (n == 8'd0) ? 8'd1 : n;
    endfunction

endpackage

// File: rtl/pix_multi_edge_sequencer_if.sv
// pix_multi_edge_sequencer_if: host-side run-control handshake.
//   start, abort        : host -> sequencer requests
//   ready, measure      : sequencer state indications
//   done, aborted       : 1-cycle completion / abort pulses
//   run_count[31:0]     : completed measurement windows
// Modports: master = host / register block, slave = sequencer.
interface pix_multi_edge_sequencer_if;

    logic        start;
    logic        abort;
    logic        ready;
    logic        measure;
    logic        done;
    logic        aborted;
    logic [31:0] run_count;

    modport master (
        output start, abort,
        input  ready, measure, done, aborted, run_count
    );

    modport slave (
        input  start, abort,
        output ready, measure, done, aborted, run_count
    );

endinterface

// File: rtl/pix_seq_edge_channel.sv
// pix_seq_edge_channel: one release-style timed output line.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : high in INIT, drops the line back into reset
//   arm        : high in MEASURE, enables the time match
//   cnt        : sequencer state counter
//   rel_time   : counter value at which the line is released
//   released   : registered line; 0 = held in reset, 1 = released
// Once released the line stays high until the next clear.
module pix_seq_edge_channel #(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             arm,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] rel_time,
    output logic             released
);

    logic edge_q, edge_d;

    always_comb begin
        edge_d = edge_q;
        if (clear)
            edge_d = 1'b0;
        else if (arm && (cnt == rel_time))
            edge_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) edge_q <= 1'b0;
        else       edge_q <= edge_d;
    end

    assign released = edge_q;

endmodule

// File: rtl/pix_multi_edge_sequencer.sv
// pix_multi_edge_sequencer: multi-channel PIX/TDC test-structure sequencer.
// INIT -> READY -> (start) MEASURE -> FINAL -> INIT, repeated n_repeats times
// per start, with abort and done reporting.
//   clk, reset    : clock, asynchronous active-high reset
//   ctl (slave)   : start/abort in; ready/measure/done/aborted/run_count out
//   edge_time     : per-line release times, line i in [i*CNT_W +: CNT_W]
//   measure_time  : MEASURE exit count
//   n_repeats     : measurements per start (0 treated as 1)
//   sel_in/sel    : channel select, loaded in INIT
//   static_in/static_out : static control bits, loaded in INIT
//   ena           : structure enable, set from the first INIT cycle on
//   edge_out      : timed release lines
// Build option PIX_SEQ_RUN_COUNTER_EN: when defined, run_count is a 32-bit
// wrapping count of completed FINAL states; otherwise it is tied to 0.
module pix_multi_edge_sequencer
    import pix_seq_pkg::*;
#(
    parameter int CNT_W       = 12,
    parameter int N_EDGE      = 4,
    parameter int SEL_W       = 4,
    parameter int N_STATIC    = 3,
    parameter int INIT_CYCLES = PIX_SEQ_INIT_CYCLES
) (
    input  logic                      clk,
    input  logic                      reset,
    pix_multi_edge_sequencer_if.slave ctl,
    input  logic [N_EDGE*CNT_W-1:0]   edge_time,
    input  logic [CNT_W-1:0]          measure_time,
    input  logic [7:0]                n_repeats,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic [N_STATIC-1:0]       static_in,
    output logic [SEL_W-1:0]          sel,
    output logic                      ena,
    output logic [N_STATIC-1:0]       static_out,
    output logic [N_EDGE-1:0]         edge_out
);

    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES);

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [7:0]              rem_q, rem_d;
    logic [N_EDGE*CNT_W-1:0] edge_time_q, edge_time_d;
    logic [CNT_W-1:0]        meas_time_q, meas_time_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [N_STATIC-1:0]     static_q, static_d;
    logic                    ena_q, ena_d;
    logic                    done_q, done_d;
    logic                    aborted_q, aborted_d;
    logic                    abort_ok;

    // A run is active exactly while repeats remain, so rem doubles as the
    // run-active flag for INIT exit and abort qualification.
    assign abort_ok = ctl.abort &&
                      ((state_q == SEQ_MEASURE) || (state_q == SEQ_FINAL) ||
                       ((state_q == SEQ_INIT) && (rem_q != 8'd0)));

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        edge_time_d = edge_time_q;
        meas_time_d = meas_time_q;
        sel_d       = sel_q;
        static_d    = static_q;
        ena_d       = ena_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;

        case (state_q)
            SEQ_INIT: begin
                ena_d    = 1'b1;
                sel_d    = sel_in;
                static_d = static_in;
                if (cnt_q == INIT_LAST)
                    state_d = (rem_q != 8'd0) ? SEQ_MEASURE : SEQ_READY;
            end
            SEQ_READY: begin
                if (ctl.start && !ctl.abort) begin
                    edge_time_d = edge_time;
                    meas_time_d = measure_time;
                    rem_d       = eff_repeats(n_repeats);
                    state_d     = SEQ_MEASURE;
                end
            end
            SEQ_MEASURE: begin
                if (cnt_q == meas_time_q)
                    state_d = SEQ_FINAL;
            end
            default: begin // SEQ_FINAL
                rem_d   = rem_q - 8'd1;
                done_d  = (rem_q == 8'd1);
                state_d = SEQ_INIT;
            end
        endcase

        // Abort overrides start and the FINAL bookkeeping.
        if (abort_ok) begin
            state_d   = SEQ_INIT;
            rem_d     = 8'd0;
            done_d    = 1'b0;
            aborted_d = 1'b1;
        end

        // Any (re-)entry clears the counter; otherwise count and saturate so a
        // match on the all-ones value is still reached.
        if ((state_d != state_q) || abort_ok)
            cnt_d = '0;
        else if (cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + CNT_W'(1);
        else
            cnt_d = cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SEQ_INIT;
            cnt_q       <= '0;
            rem_q       <= 8'd0;
            edge_time_q <= '0;
            meas_time_q <= '0;
            sel_q       <= '0;
            static_q    <= '0;
            ena_q       <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            edge_time_q <= edge_time_d;
            meas_time_q <= meas_time_d;
            sel_q       <= sel_d;
            static_q    <= static_d;
            ena_q       <= ena_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_EDGE; g++) begin : g_ch
            pix_seq_edge_channel #(.CNT_W(CNT_W)) u_ch (
                .clk      (clk),
                .reset    (reset),
                .clear    (state_q == SEQ_INIT),
                .arm      (state_q == SEQ_MEASURE),
                .cnt      (cnt_q),
                .rel_time (edge_time_q[g*CNT_W +: CNT_W]),
                .released (edge_out[g])
            );
        end
    endgenerate

`ifdef PIX_SEQ_RUN_COUNTER_EN
    logic [31:0] run_count_q, run_count_d;
    always_comb begin
        run_count_d = run_count_q;
        if ((state_q == SEQ_FINAL) && !abort_ok)
            run_count_d = run_count_q + 32'd1;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) run_count_q <= 32'd0;
        else       run_count_q <= run_count_d;
    end
    assign ctl.run_count = run_count_q;
`else
    assign ctl.run_count = 32'd0;
`endif

    assign ctl.ready   = (state_q == SEQ_READY);
    assign ctl.measure = (state_q == SEQ_MEASURE);
    assign ctl.done    = done_q;
    assign ctl.aborted = aborted_q;
    assign sel         = sel_q;
    assign ena         = ena_q;
    assign static_out  = static_q;

endmodule

// File: tb/tb_pix_multi_edge_sequencer.sv
// tb_pix_multi_edge_sequencer: directed-vector bench for the PIX sequencer.
module tb_pix_multi_edge_sequencer;

    localparam int CNT_W = 12, N_EDGE = 4, SEL_W = 4, N_STATIC = 3;
`ifdef PIX_SEQ_RUN_COUNTER_EN
    localparam bit RC_EN = 1'b1;
`else
    localparam bit RC_EN = 1'b0;
`endif

    logic                    clk, reset;
    logic [N_EDGE*CNT_W-1:0] edge_time;
    logic [CNT_W-1:0]        measure_time;
    logic [7:0]              n_repeats;
    logic [SEL_W-1:0]        sel_in, sel;
    logic [N_STATIC-1:0]     static_in, static_out;
    logic                    ena;
    logic [N_EDGE-1:0]       edge_out;

    pix_multi_edge_sequencer_if ctl();

    pix_multi_edge_sequencer #(
        .CNT_W(CNT_W), .N_EDGE(N_EDGE), .SEL_W(SEL_W), .N_STATIC(N_STATIC), .INIT_CYCLES(20)
    ) dut (
        .clk(clk), .reset(reset), .ctl(ctl),
        .edge_time(edge_time), .measure_time(measure_time), .n_repeats(n_repeats),
        .sel_in(sel_in), .static_in(static_in), .sel(sel), .ena(ena),
        .static_out(static_out), .edge_out(edge_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int n_done, n_meas;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return 32'({ctl.ready, ctl.measure, ctl.done, ctl.aborted, sel, ena, static_out, edge_out});
    endfunction

    function automatic logic [31:0] rc_exp(input int n);
        return RC_EN ? 32'(n) : 32'd0;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        ctl.start = 1'b0;
        ctl.abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Tick until ready (bounded), counting done pulses and MEASURE cycles seen.
    task automatic wait_ready(input string tag, input int limit);
        n_done = 0;
        n_meas = 0;
        for (int k = 0; k < limit && !ctl.ready; k++) begin
            tick();
            if (ctl.done)    n_done++;
            if (ctl.measure) n_meas++;
        end
        chk(tag, 32'(ctl.ready), 32'd1);
    endtask

    // Runs the current MEASURE window; returns its length and first-seen
    // cycle of each line relative to MEASURE entry (cycle 0).
    task automatic run_window(output int mc, output int rise [N_EDGE]);
        mc = 0;
        for (int i = 0; i < N_EDGE; i++) rise[i] = -1;
        while (ctl.measure && mc < 5000) begin
            for (int i = 0; i < N_EDGE; i++)
                if (edge_out[i] && rise[i] < 0) rise[i] = mc;
            mc++;
            tick();
        end
    endtask

    task automatic pulse_start();
        ctl.start = 1'b1;
        tick();
        ctl.start = 1'b0;
    endtask

    initial begin : main
        int mc, win, dn, idx;
        int rise [N_EDGE];
        int exp_rise [N_EDGE];
        logic prev_m, seen;

        sel_in = 4'hA;
        static_in = 3'b101;
        edge_time = '0;
        measure_time = '0;
        n_repeats = 8'd0;

        // ---- reset and INIT dwell ----
        reset = 1'b1;
        ctl.start = 1'b0;
        ctl.abort = 1'b0;
        #2;
        chk("rst_outs", outs(), 32'd0);
        chk("rst_runcnt", ctl.run_count, 32'd0);
        do_reset();
        tick();
        chk("ena_clk1", 32'(ena), 32'd1);
        repeat (19) tick();
        chk("ready_clk20", 32'(ctl.ready), 32'd0);
        tick();
        chk("ready_clk21", 32'(ctl.ready), 32'd1);
        chk("idle_edges", 32'(edge_out), 32'd0);
        chk("sel_loaded", 32'(sel), 32'hA);
        chk("static_loaded", 32'(static_out), 32'h5);

        // ---- single run, staggered edges ----
        edge_time[0*CNT_W +: CNT_W] = 12'd30;
        edge_time[1*CNT_W +: CNT_W] = 12'd5;
        edge_time[2*CNT_W +: CNT_W] = 12'd0;
        edge_time[3*CNT_W +: CNT_W] = 12'd10;
        measure_time = 12'd40;
        n_repeats = 8'd1;
        pulse_start();
        chk("meas_entry", 32'(ctl.measure), 32'd1);
        exp_rise = '{31, 6, 1, 11};
        run_window(mc, rise);
        for (int i = 0; i < N_EDGE; i++)
            chk($sformatf("rise%0d", i), 32'(rise[i]), 32'(exp_rise[i]));
        chk("meas_len41", 32'(mc), 32'd41);
        chk("done_in_final", 32'(ctl.done), 32'd0);
        tick();
        chk("done_pulse", 32'(ctl.done), 32'd1);
        tick();
        chk("done_drop", 32'(ctl.done), 32'd0);
        wait_ready("ready_after_run", 100);
        chk("extra_done", 32'(n_done), 32'd0);
        chk("runcnt_1", ctl.run_count, rc_exp(1));

        // ---- three repeats with start held high ----
        do_reset();
        wait_ready("ready_rep3", 100);
        edge_time = '0;
        measure_time = 12'd8;
        n_repeats = 8'd3;
        ctl.start = 1'b1;
        win = 0; dn = 0; prev_m = 1'b0; seen = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (ctl.measure && !prev_m) win++;
            prev_m = ctl.measure;
            if (ctl.done) dn++;
            if (dn == 1 && ctl.ready) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rep3_ready", 32'(seen), 32'd1);
        chk("rep3_windows", 32'(win), 32'd3);
        chk("rep3_done", 32'(dn), 32'd1);
        chk("rep3_runcnt", ctl.run_count, rc_exp(3));
        tick();
        chk("restart_held", 32'(ctl.measure), 32'd1);
        ctl.start = 1'b0;

        // ---- abort in MEASURE cycle 10 of repeat 2 of 4 ----
        do_reset();
        wait_ready("ready_abort", 100);
        edge_time = {4{12'd3}};
        measure_time = 12'd30;
        n_repeats = 8'd4;
        ctl.start = 1'b1;
        win = 0; idx = 0; prev_m = 1'b0; seen = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (k == 0) ctl.start = 1'b0;
            if (ctl.measure && !prev_m) begin
                win++;
                idx = 0;
            end else if (ctl.measure) begin
                idx++;
            end
            prev_m = ctl.measure;
            if (win == 2 && ctl.measure && idx == 10) begin
                seen = 1'b1;
                break;
            end
        end
        chk("abort_reach", 32'(seen), 32'd1);
        ctl.abort = 1'b1;
        tick();
        ctl.abort = 1'b0;
        chk("aborted_pulse", 32'(ctl.aborted), 32'd1);
        chk("abort_meas_off", 32'(ctl.measure), 32'd0);
        tick();
        chk("abort_edges_clr", 32'(edge_out), 32'd0);
        chk("aborted_drop", 32'(ctl.aborted), 32'd0);
        wait_ready("ready_after_abort", 100);
        chk("abort_no_done", 32'(n_done), 32'd0);
        chk("abort_no_meas", 32'(n_meas), 32'd0);
        chk("abort_runcnt", ctl.run_count, rc_exp(1));

        // ---- start+abort together, late edge, n_repeats=0 ----
        do_reset();
        wait_ready("ready_late", 100);
        edge_time = {12'd20, 12'd20, 12'd20, 12'd50};
        measure_time = 12'd20;
        n_repeats = 8'd0;
        ctl.start = 1'b1;
        ctl.abort = 1'b1;
        tick();
        ctl.start = 1'b0;
        ctl.abort = 1'b0;
        chk("sa_no_meas", 32'(ctl.measure), 32'd0);
        chk("sa_ready", 32'(ctl.ready), 32'd1);
        chk("sa_no_abort", 32'(ctl.aborted), 32'd0);
        pulse_start();
        run_window(mc, rise);
        chk("late_len21", 32'(mc), 32'd21);
        chk("late_edges", 32'(edge_out), 32'hE);
        tick();
        chk("zero_rep_done", 32'(ctl.done), 32'd1);
        wait_ready("ready_late_end", 100);

        // ---- counter saturation ----
        edge_time = {12'd0, 12'd0, 12'd0, 12'hFFF};
        measure_time = 12'hFFF;
        n_repeats = 8'd1;
        pulse_start();
        run_window(mc, rise);
        chk("sat_len", 32'(mc), 32'd4096);
        chk("sat_edges", 32'(edge_out), 32'hF);
        tick();
        chk("sat_done", 32'(ctl.done), 32'd1);
        wait_ready("ready_sat", 100);

        // ---- asynchronous reset mid-MEASURE ----
        edge_time = '0;
        measure_time = 12'd40;
        pulse_start();
        repeat (5) tick();
        chk("pre_rst_meas", 32'(ctl.measure), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_outs", outs(), 32'd0);
        chk("async_rst_runcnt", ctl.run_count, 32'd0);
        #2;
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
